// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Timing constants for 640x480 @ 60 Hz VGA on a 25 MHz pixel clock.
// Shared by vga_axis_timer and vga_timing_gen.
//
// Contents:
//   coord_t                   10-bit unsigned pixel/line coordinate
//   H_* / V_*                 region widths and totals per axis
//   H_SYNC_START/END, V_...   first and last coordinate of each sync pulse
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   typedef logic [9:0] coord_t;

   // Horizontal timing, in pixel clocks
   localparam coord_t H_VISIBLE = 10'd640;
   localparam coord_t H_FP      = 10'd16;
   localparam coord_t H_SYNC    = 10'd96;
   localparam coord_t H_BP      = 10'd48;
   localparam coord_t H_TOTAL   = 10'd800;

   // Vertical timing, in lines
   localparam coord_t V_VISIBLE = 10'd480;
   localparam coord_t V_FP      = 10'd10;
   localparam coord_t V_SYNC    = 10'd2;
   localparam coord_t V_BP      = 10'd33;
   localparam coord_t V_TOTAL   = 10'd525;

   // Sync pulses sit directly after the front porch; END is inclusive.
   localparam coord_t H_SYNC_START = H_VISIBLE + H_FP;            // 656
   localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1; // 751
   localparam coord_t V_SYNC_START = V_VISIBLE + V_FP;            // 490
   localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1; // 491

endpackage : vga_timing_pkg

// File: rtl/vga_axis_timer.sv
// -----------------------------------------------------------------------------
// vga_axis_timer
// One axis (horizontal or vertical) of the VGA raster. Holds a wrapping
// counter and looks one edge ahead so the parent can register its
// visible/sync outputs on the same edge that the counter moves.
//
// Ports:
//   vga_clk       in   pixel clock, rising edge
//   reset         in   asynchronous, active-high
//   enable        in   advance the counter this cycle
//   total         in   number of positions on this axis (counter wraps total-1 -> 0)
//   visible       in   positions 0..visible-1 are visible
//   sync_start    in   first position of the sync pulse
//   sync_end      in   last position of the sync pulse (inclusive)
//   count         out  current position (registered)
//   wrap          out  counter moves total-1 -> 0 on the coming edge
//   visible_next  out  position after the coming edge is visible
//   sync_n_next   out  active-low sync for the position after the coming edge
// -----------------------------------------------------------------------------
module vga_axis_timer
   import vga_timing_pkg::*;
(
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [9:0] total,
   input  logic [9:0] visible,
   input  logic [9:0] sync_start,
   input  logic [9:0] sync_end,
   output logic [9:0] count,
   output logic       wrap,
   output logic       visible_next,
   output logic       sync_n_next
);

   coord_t count_next;

   // NOTE: every signal assigned here gets a value on every path (defaults
   // first), otherwise synthesis would infer a latch to hold the old value.
   always_comb begin
      wrap         = enable && (count == total - 10'd1);
      count_next   = count;
      if (enable) begin
         count_next = wrap ? '0 : count + 10'd1;
      end
      visible_next = (count_next < visible);
      sync_n_next  = !((count_next >= sync_start) && (count_next <= sync_end));
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of block evaluation order.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule : vga_axis_timer

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// 640x480 @ 60 Hz VGA raster timing generator. Two vga_axis_timer instances
// form an 800 x 525 raster; hs, vs and blank are registered from the timers'
// look-ahead values so they change on the same edge as DrawX/DrawY.
//
// Ports:
//   vga_clk      in   pixel clock (25 MHz nominal), rising edge
//   reset        in   asynchronous, active-high
//   hs           out  horizontal sync, active low (DrawX 656..751)
//   vs           out  vertical sync, active low (DrawY 490..491)
//   blank        out  1 = visible pixel (DrawX < 640 and DrawY < 480)
//   DrawX        out  current column, 0..799
//   DrawY        out  current line, 0..524
//   frame_start  out  (VGA_FRAME_STATUS_EN only) one-cycle pulse with (0,0)
//                     following a frame wrap
//   frame_count  out  (VGA_FRAME_STATUS_EN only) frames completed, wraps at 2^16
//
// Build option: define VGA_FRAME_STATUS_EN to add frame_start/frame_count.
//
// Every output comes straight from a flop, so there is no input-to-output
// combinational path. Reset yields blank = 0 at (0,0), so pixel (0,0) is
// suppressed only in the first frame after reset.
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
(
   input  logic       vga_clk,
   input  logic       reset,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY
`ifdef VGA_FRAME_STATUS_EN
   ,
   output logic        frame_start,
   output logic [15:0] frame_count
`endif
);

   logic h_wrap;
   logic h_visible_next;
   logic h_sync_n_next;
   logic v_visible_next;
   logic v_sync_n_next;

`ifdef VGA_FRAME_STATUS_EN
   logic v_wrap;
`else
   // Vertical wrap only drives the frame status logic, absent in this build.
   logic v_wrap_unused;
`endif

   vga_axis_timer u_h_timer (
      .vga_clk      (vga_clk),
      .reset        (reset),
      .enable       (1'b1),
      .total        (H_TOTAL),
      .visible      (H_VISIBLE),
      .sync_start   (H_SYNC_START),
      .sync_end     (H_SYNC_END),
      .count        (DrawX),
      .wrap         (h_wrap),
      .visible_next (h_visible_next),
      .sync_n_next  (h_sync_n_next)
   );

   // Vertical axis advances only on the cycle the horizontal axis wraps.
   vga_axis_timer u_v_timer (
      .vga_clk      (vga_clk),
      .reset        (reset),
      .enable       (h_wrap),
      .total        (V_TOTAL),
      .visible      (V_VISIBLE),
      .sync_start   (V_SYNC_START),
      .sync_end     (V_SYNC_END),
      .count        (DrawY),
`ifdef VGA_FRAME_STATUS_EN
      .wrap         (v_wrap),
`else
      .wrap         (v_wrap_unused),
`endif
      .visible_next (v_visible_next),
      .sync_n_next  (v_sync_n_next)
   );

   // Registered from next-state values: lands on the same edge as DrawX/DrawY.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hs    <= 1'b1;
         vs    <= 1'b1;
         blank <= 1'b0;
      end else begin
         hs    <= h_sync_n_next;
         vs    <= v_sync_n_next;
         blank <= h_visible_next && v_visible_next;
      end
   end

`ifdef VGA_FRAME_STATUS_EN
   // v_wrap is only true when h_wrap is (it is the vertical enable), so it
   // marks exactly the (799,524) -> (0,0) edge.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_start <= v_wrap;
         if (v_wrap) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end
`endif

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Scoreboard bench for vga_timing_gen. The stimulus process pushes the
// expected output set for every clock edge (and for the asynchronous reset
// point); the monitor pops and compares at the falling edge. Expected values
// come from a linear pixel index p (edges since reset release):
// x = p mod 800, y = (p / 800) mod 525, with region limits written as literals.
// Frame-level totals are gathered by the monitor and compared at the end.
// Honours VGA_FRAME_STATUS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic       vga_clk = 1'b0;
   logic       reset   = 1'b1;
   logic       hs;
   logic       vs;
   logic       blank;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
`ifdef VGA_FRAME_STATUS_EN
   logic        frame_start;
   logic [15:0] frame_count;
`endif

   vga_timing_gen dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .hs          (hs),
      .vs          (vs),
      .blank       (blank),
      .DrawX       (DrawX),
      .DrawY       (DrawY)
`ifdef VGA_FRAME_STATUS_EN
      ,
      .frame_start (frame_start),
      .frame_count (frame_count)
`endif
   );

   always #20 vga_clk = ~vga_clk;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        hs;
      logic        vs;
      logic        blank;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   obs_t        sb_q[$];
   int          checks   = 0;
   int          passed   = 0;
   bit          abort    = 1'b0;
   bit          stats_on = 1'b0;
   event        chk_ev;
   int unsigned p        = 0;

   // Frame statistics gathered by the monitor (second run only)
   int unsigned n_since_rst = 0;
   int unsigned hs_low      = 0;
   int unsigned vs_low      = 0;
   int unsigned blank_hi    = 0;
   int unsigned frame_len   = 0;
   int unsigned line0_hs    = 0;
   int          hs_first    = -1;
   int          hs_last     = -1;

   task automatic check(input string name, input bit ok, input string detail);
      checks++;
      if (ok) passed++;
      else    $display("FAIL %s: %s", name, detail);
   endtask

   function automatic string fmt(input obs_t o);
      return $sformatf("x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d",
                       o.x, o.y, o.hs, o.vs, o.blank, o.fs, o.fc);
   endfunction

   function automatic obs_t reset_obs();
      obs_t o;
      o.x = '0; o.y = '0; o.hs = 1'b1; o.vs = 1'b1; o.blank = 1'b0;
      o.fs = 1'b0; o.fc = '0;
      return o;
   endfunction

   // Expected outputs after edge number pp since reset release.
   function automatic obs_t model(input int unsigned pp);
      obs_t        o;
      int unsigned pos = pp % 420000;
      int unsigned xi  = pos % 800;
      int unsigned yi  = pos / 800;
      o.x     = 10'(xi);
      o.y     = 10'(yi);
      o.hs    = !(xi >= 656 && xi <= 751);
      o.vs    = !(yi >= 490 && yi <= 491);
      o.blank = (xi < 640) && (yi < 480);
`ifdef VGA_FRAME_STATUS_EN
      o.fs    = (pp != 0) && (pos == 0);
      o.fc    = 16'(pp / 420000);
`else
      o.fs    = 1'b0;
      o.fc    = '0;
`endif
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.x = DrawX; o.y = DrawY; o.hs = hs; o.vs = vs; o.blank = blank;
`ifdef VGA_FRAME_STATUS_EN
      o.fs = frame_start; o.fc = frame_count;
`else
      o.fs = 1'b0; o.fc = '0;
`endif
      return o;
   endfunction

   // One clock edge of stimulus: queue the response expected after it.
   task automatic step();
      @(posedge vga_clk);
      if (reset) begin
         p = 0;
         sb_q.push_back(reset_obs());
      end else begin
         p++;
         sb_q.push_back(model(p));
      end
   endtask

   // Monitor: pop and compare whenever outputs are presented.
   initial begin
      obs_t e;
      obs_t a;
      forever begin
         @(negedge vga_clk or chk_ev);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = sample();
            check("pixel", a === e, $sformatf("p=%0d got %s want %s", p, fmt(a), fmt(e)));
            if (checks - passed >= 50) abort = 1'b1;
            if (reset) begin
               n_since_rst = 0;
            end else begin
               n_since_rst++;
               if (stats_on && n_since_rst <= 420000) begin
                  if (!hs)    hs_low++;
                  if (!vs)    vs_low++;
                  if (blank)  blank_hi++;
                  if (DrawX == 10'd0 && DrawY == 10'd0 && frame_len == 0)
                     frame_len = n_since_rst;
                  if (n_since_rst < 800 && DrawY == 10'd0 && !hs) begin
                     line0_hs++;
                     if (hs_first < 0) hs_first = int'(DrawX);
                     hs_last = int'(DrawX);
                  end
               end
            end
         end
      end
   end

   initial begin
      // Reset held for 5 edges.
      reset = 1'b1;
      repeat (5) step();
      #30 reset = 1'b0;

      // Run to (300,200) of the first frame.
      while (p != 160300 && !abort) step();

      // Asynchronous reset mid-cycle: values must change before the next edge.
      if (!abort) begin
         #25 reset = 1'b1;
         #2;
         sb_q.push_back(reset_obs());
         ->chk_ev;
         repeat (2) step();
         stats_on = 1'b1;
         #30 reset = 1'b0;
      end

      // One full frame plus the wrap into the next.
      for (int i = 0; i < 420005 && !abort; i++) step();

      @(negedge vga_clk);
      #1;
      check("queue_drained", sb_q.size() == 0, $sformatf("got %0d left want 0", sb_q.size()));
      check("hs_low_frame", hs_low == 50400, $sformatf("got %0d want 50400", hs_low));
      check("vs_low_frame", vs_low == 1600, $sformatf("got %0d want 1600", vs_low));
      check("blank_hi_frame", blank_hi == 307200, $sformatf("got %0d want 307200", blank_hi));
      check("frame_len", frame_len == 420000, $sformatf("got %0d want 420000", frame_len));
      check("line0_hs_len", line0_hs == 96, $sformatf("got %0d want 96", line0_hs));
      check("line0_hs_first", hs_first == 656, $sformatf("got %0d want 656", hs_first));
      check("line0_hs_last", hs_last == 751, $sformatf("got %0d want 751", hs_last));
      check("line0_hs_contig", line0_hs == 32'(hs_last - hs_first + 1),
            $sformatf("got run %0d over span %0d..%0d", line0_hs, hs_first, hs_last));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_vga_timing_gen
